pipe_stage_skid: RTL

//  Parametrised pipeline stage register: successor to the fixed ID->EX latch.

---
 rtl/pipe_stage_skid.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Every output comes straight from a flop or from decoding the state register.
module pipe_stage_skid #(
  parameter int                CTRL_W      = 9,
  parameter int                DATA_W      = 143,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CTRL_W-1:0]  main_ctrl_r;
  logic [DATA_W-1:0]  main_data_r;
  logic [CTRL_W-1:0]  skid_ctrl_r;
  logic [DATA_W-1:0]  skid_data_r;
  logic               take_in_s;
  logic               take_out_s;

  assign take_in_s  = in_valid && in_ready;
  assign take_out_s = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (take_in_s) state_next_s = ST_ONE;
          else           state_next_s = ST_EMPTY;
        end
        ST_ONE: begin
          if (take_in_s && !take_out_s)      state_next_s = ST_FULL;
          else if (!take_in_s && take_out_s) state_next_s = ST_EMPTY;
          else                               state_next_s = ST_ONE;
        end
        ST_FULL: begin
          if (take_out_s) state_next_s = ST_ONE;
          else            state_next_s = ST_FULL;
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Handshake and occupancy decode from the state register only
  always_comb begin
    in_ready  = (state_r != ST_FULL);
    out_valid = (state_r != ST_EMPTY);
    case (state_r)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Main/skid storage; main_ctrl_r is forced to BUBBLE_CTRL on every path into EMPTY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl_r <= BUBBLE_CTRL;
      main_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else if (flush) begin
      main_ctrl_r <= BUBBLE_CTRL;
      main_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (take_in_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
          end
        end
        ST_ONE: begin
          if (take_in_s && take_out_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
          end else if (take_in_s) begin
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
          end else if (take_out_s) begin
            main_ctrl_r <= BUBBLE_CTRL;
          end
        end
        ST_FULL: begin
          if (take_out_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
          end
        end
        default: begin
          main_ctrl_r <= BUBBLE_CTRL;
        end
      endcase
    end
  end

  assign out_ctrl = main_ctrl_r;
  assign out_data = main_data_r;

endmodule
